// File: rtl/wb_reg_bank_if.sv
// rtl/wb_reg_bank_if.sv - Wishbone slave bus bundle for the register bank
// Signal names follow the bank's Wishbone port list; modports give the master and slave views.
interface wb_reg_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] wb_addr_i;
  logic [DATA_WIDTH-1:0] wb_data_i;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic                  wb_we_i;
  logic                  wb_cycle_i;
  logic                  wb_strobe_i;
  logic                  wb_sel_i;
  logic                  wb_ack_o;
  logic                  wb_stall_o;

  modport master (
    output wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i, wb_sel_i,
    input  wb_data_o, wb_ack_o, wb_stall_o
  );

  modport slave (
    input  wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i, wb_sel_i,
    output wb_data_o, wb_ack_o, wb_stall_o
  );
endinterface

// File: rtl/wb_reg_bank.sv
// rtl/wb_reg_bank.sv - parametrised Wishbone register bank
// Control, synchronised status, sticky W1C events with per-register interrupt masks.
module wb_reg_bank #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_CTRL    = 4,
  parameter int NUM_STATUS  = 2,
  parameter int NUM_EVENT   = 1,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_CTRL*DATA_WIDTH-1:0] CTRL_RESET = '0
) (
  input  logic                             wb_clock_i,
  input  logic                             wb_reset_ni,
  wb_reg_bank_if.slave                     wb,
  input  logic [NUM_STATUS*DATA_WIDTH-1:0] status_i,
  input  logic [NUM_EVENT*DATA_WIDTH-1:0]  event_i,
  output logic [NUM_CTRL*DATA_WIDTH-1:0]   ctrl_o,
  output logic [NUM_CTRL-1:0]              ctrl_wr_o,
  output logic                             irq_o
);

  localparam int STATUS_BASE = NUM_CTRL;
  localparam int EVENT_BASE  = NUM_CTRL + NUM_STATUS;
  localparam int MASK_BASE   = EVENT_BASE + NUM_EVENT;
  localparam int MAP_SIZE    = MASK_BASE + NUM_EVENT;
  localparam int IN_W        = (NUM_STATUS + NUM_EVENT) * DATA_WIDTH;
  localparam int WARM_CYCLES = SYNC_STAGES + 1;

  if (MAP_SIZE > (1 << ADDR_WIDTH)) begin : g_map_check
    $error("wb_reg_bank: register map does not fit the address space");
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_sync_check
    $error("wb_reg_bank: SYNC_STAGES must be 0..3");
  end

  // Status and event inputs share one synchroniser chain.
  logic [IN_W-1:0] in_raw;
  logic [IN_W-1:0] in_sync;

  assign in_raw = {event_i, status_i};

  if (SYNC_STAGES == 0) begin : g_nosync
    assign in_sync = in_raw;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][IN_W-1:0] sync_q;

    always_ff @(posedge wb_clock_i) begin
      if (!wb_reset_ni) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= in_raw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];
  end

  logic [NUM_STATUS-1:0][DATA_WIDTH-1:0] status_sync;
  logic [NUM_EVENT-1:0][DATA_WIDTH-1:0]  event_sync;

  assign status_sync = in_sync[NUM_STATUS*DATA_WIDTH-1:0];
  assign event_sync  = in_sync[IN_W-1 -: NUM_EVENT*DATA_WIDTH];

  // Edge detection stays off until the synchroniser has flushed its reset zeros.
  logic [2:0] warm_cnt;
  logic       warm_done;

  assign warm_done = (warm_cnt == 3'(WARM_CYCLES));

  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_ni) begin
      warm_cnt <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + 3'd1;
    end
  end

  logic [NUM_EVENT-1:0][DATA_WIDTH-1:0] ev_prev;
  logic [NUM_EVENT-1:0][DATA_WIDTH-1:0] ev_rise;

  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_ni) begin
      ev_prev <= '0;
      ev_rise <= '0;
    end else begin
      ev_prev <= event_sync;
      ev_rise <= warm_done ? (event_sync & ~ev_prev) : '0;
    end
  end

  // Accepted transfer is held one cycle; its write and ack both land on the next edge.
  logic                  req_valid;
  logic                  req_we;
  logic                  req_sel;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;

  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_ni) begin
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_sel   <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
    end else begin
      req_valid <= wb.wb_cycle_i & wb.wb_strobe_i;
      req_we    <= wb.wb_we_i;
      req_sel   <= wb.wb_sel_i;
      req_addr  <= wb.wb_addr_i;
      req_data  <= wb.wb_data_i;
    end
  end

  logic wr_en;
  assign wr_en = req_valid & req_we & req_sel;

  logic [NUM_CTRL-1:0][DATA_WIDTH-1:0]  ctrl_q;
  logic [NUM_EVENT-1:0][DATA_WIDTH-1:0] ev_q;
  logic [NUM_EVENT-1:0][DATA_WIDTH-1:0] mask_q;

  logic [NUM_CTRL-1:0]                  ctrl_we;
  logic [NUM_EVENT-1:0]                 mask_we;
  logic [NUM_EVENT-1:0][DATA_WIDTH-1:0] ev_clr;
  logic [DATA_WIDTH-1:0]                rd_data;

  always_comb begin
    ctrl_we = '0;
    mask_we = '0;
    ev_clr  = '0;
    rd_data = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (int'(req_addr) == k) begin
        rd_data    = ctrl_q[k];
        ctrl_we[k] = wr_en;
      end
    end
    for (int s = 0; s < NUM_STATUS; s++) begin
      if (int'(req_addr) == STATUS_BASE + s) begin
        rd_data = status_sync[s];
      end
    end
    for (int e = 0; e < NUM_EVENT; e++) begin
      if (int'(req_addr) == EVENT_BASE + e) begin
        rd_data   = ev_q[e];
        ev_clr[e] = wr_en ? req_data : '0;
      end
      if (int'(req_addr) == MASK_BASE + e) begin
        rd_data    = mask_q[e];
        mask_we[e] = wr_en;
      end
    end
  end

  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_ni) begin
      ctrl_q    <= CTRL_RESET;
      ctrl_wr_o <= '0;
    end else begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (ctrl_we[k]) begin
          ctrl_q[k] <= req_data;
        end
      end
      ctrl_wr_o <= ctrl_we;
    end
  end

  // A new edge beats a simultaneous write-1-to-clear of the same bit.
  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_ni) begin
      ev_q   <= '0;
      mask_q <= '0;
      irq_o  <= 1'b0;
    end else begin
      ev_q <= (ev_q & ~ev_clr) | ev_rise;
      for (int e = 0; e < NUM_EVENT; e++) begin
        if (mask_we[e]) begin
          mask_q[e] <= req_data;
        end
      end
      irq_o <= |(ev_q & mask_q);
    end
  end

  logic                  ack_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_ni) begin
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ack_q  <= req_valid;
      data_q <= req_valid ? rd_data : '0;
    end
  end

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_data_o  = data_q;
  assign wb.wb_stall_o = 1'b0;
  assign ctrl_o        = ctrl_q;

endmodule

// File: tb/tb_wb_reg_bank.sv
// tb/tb_wb_reg_bank.sv - scoreboard bench for wb_reg_bank
// Map: ctrl 0-3, status 4-5, event 6, mask 7, everything else unmapped.
module tb_wb_reg_bank;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] status_i = '0;
  logic [7:0]  event_i = 8'h01;
  logic [31:0] ctrl_o;
  logic [3:0]  ctrl_wr_o;
  logic        irq_o;

  wb_reg_bank_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

  wb_reg_bank #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (5),
    .NUM_CTRL   (4),
    .NUM_STATUS (2),
    .NUM_EVENT  (1),
    .SYNC_STAGES(2),
    .CTRL_RESET (32'h0000_0002)
  ) dut (
    .wb_clock_i (clk),
    .wb_reset_ni(resetn),
    .wb         (bus),
    .status_i   (status_i),
    .event_i    (event_i),
    .ctrl_o     (ctrl_o),
    .ctrl_wr_o  (ctrl_wr_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         cyc;
    bit         rd;
    int         addr;
    logic [7:0] data;
  } sb_t;
  sb_t sb_q[$];

  // Reference model of the firmware-visible registers
  logic [7:0] ctrl_m[4];
  logic [7:0] ev_m;
  logic [7:0] mask_m;

  task automatic model_reset();
    ctrl_m[0] = 8'h02;
    ctrl_m[1] = 8'h00;
    ctrl_m[2] = 8'h00;
    ctrl_m[3] = 8'h00;
    ev_m      = 8'h00;
    mask_m    = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input int a);
    if (a < 4) return ctrl_m[a];
    if (a == 4) return status_i[7:0];
    if (a == 5) return status_i[15:8];
    if (a == 6) return ev_m;
    if (a == 7) return mask_m;
    return 8'h00;
  endfunction

  task automatic model_write(input int a, input logic [7:0] d);
    if (a < 4) ctrl_m[a] = d;
    else if (a == 6) ev_m = ev_m & ~d;
    else if (a == 7) mask_m = d;
  endtask

  // Monitor: every ack must match the oldest outstanding transfer
  always @(negedge clk) begin
    if (bus.wb_ack_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("ack_cycle", cyc_cnt, e.cyc);
        check("stall", {31'd0, bus.wb_stall_o}, 32'd0);
        if (e.rd) check($sformatf("read_a%0d", e.addr), {24'd0, bus.wb_data_o}, {24'd0, e.data});
      end
    end
  end

  task automatic issue(input bit we, input int a, input logic [7:0] d, input bit sel);
    sb_t e;
    bus.wb_cycle_i  = 1'b1;
    bus.wb_strobe_i = 1'b1;
    bus.wb_we_i     = we;
    bus.wb_addr_i   = 5'(a);
    bus.wb_data_i   = d;
    bus.wb_sel_i    = sel;
    e.rd   = !we;
    e.addr = a;
    e.data = model_read(a);
    if (we && sel) model_write(a, d);
    @(posedge clk);
    #1;
    e.cyc = cyc_cnt + 1;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    bus.wb_cycle_i  = 1'b0;
    bus.wb_strobe_i = 1'b0;
    bus.wb_we_i     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_cycle_i  = 1'b0;
    bus.wb_strobe_i = 1'b0;
    bus.wb_we_i     = 1'b0;
    bus.wb_sel_i    = 1'b0;
    bus.wb_addr_i   = '0;
    bus.wb_data_i   = '0;
    model_reset();

    wait_cycles(3);
    check("rst_ctrl0", {24'd0, ctrl_o[7:0]}, 32'h02);
    check("rst_ctrl_all", ctrl_o, 32'h0000_0002);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    check("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    check("rst_ctrl_wr", {28'd0, ctrl_wr_o}, 32'd0);

    // event_i[0] was high through reset: warm-up must swallow it
    resetn = 1'b1;
    wait_cycles(6);
    for (int a = 0; a < 32; a++) issue(1'b0, a, 8'h00, 1'b0);
    idle();
    check("warm_irq", {31'd0, irq_o}, 32'd0);

    issue(1'b1, 1, 8'h5A, 1'b1);
    issue(1'b0, 1, 8'h00, 1'b0);
    check("ctrl_wr_pulse", {28'd0, ctrl_wr_o}, 32'b0010);
    idle();
    check("ctrl_wr_single", {28'd0, ctrl_wr_o}, 32'd0);
    check("ctrl1_out", {24'd0, ctrl_o[15:8]}, 32'h5A);

    status_i = 16'h00A5;
    wait_cycles(2);
    issue(1'b0, 4, 8'h00, 1'b0);
    issue(1'b1, 4, 8'hFF, 1'b1);
    issue(1'b0, 4, 8'h00, 1'b0);
    idle();

    event_i = 8'h09;
    wait_cycles(2);
    event_i = 8'h01;
    wait_cycles(6);
    ev_m = ev_m | 8'h08;
    issue(1'b0, 6, 8'h00, 1'b0);
    idle();
    check("irq_masked", {31'd0, irq_o}, 32'd0);
    issue(1'b1, 7, 8'h08, 1'b1);
    idle();
    wait_cycles(2);
    check("irq_unmasked", {31'd0, irq_o}, 32'd1);
    issue(1'b1, 6, 8'h08, 1'b1);
    issue(1'b0, 6, 8'h00, 1'b0);
    idle();
    wait_cycles(2);
    check("irq_cleared", {31'd0, irq_o}, 32'd0);

    // New edge sets bit 3 on the very edge the W1C of bit 3 lands
    event_i = 8'h09;
    wait_cycles(2);
    issue(1'b1, 6, 8'h08, 1'b1);
    ev_m = ev_m | 8'h08;
    idle();
    event_i = 8'h01;
    wait_cycles(4);
    issue(1'b0, 6, 8'h00, 1'b0);
    idle();
    check("irq_set_wins", {31'd0, irq_o}, 32'd1);
    issue(1'b1, 6, 8'h08, 1'b1);
    issue(1'b0, 6, 8'h00, 1'b0);
    idle();
    wait_cycles(2);
    check("irq_final_clear", {31'd0, irq_o}, 32'd0);

    status_i = 16'($urandom);
    wait_cycles(3);
    for (int i = 0; i < 80; i++) begin
      int a;
      a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(8, 31));
      if (a == 6 && ev_m == 8'h00) a = 7;
      issue(1'($urandom_range(0, 1)), a, 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    idle();
    check("ctrl_o_after_random", ctrl_o, {ctrl_m[3], ctrl_m[2], ctrl_m[1], ctrl_m[0]});

    issue(1'b1, 20, 8'hFF, 1'b1);
    issue(1'b0, 20, 8'h00, 1'b0);
    for (int a = 0; a < 8; a++) issue(1'b0, a, 8'h00, 1'b0);
    idle();

    // Reset lands on the edge that would apply the write and raise ack
    bus.wb_cycle_i  = 1'b1;
    bus.wb_strobe_i = 1'b1;
    bus.wb_we_i     = 1'b1;
    bus.wb_sel_i    = 1'b1;
    bus.wb_addr_i   = 5'd0;
    bus.wb_data_i   = 8'h77;
    @(posedge clk);
    #1;
    resetn          = 1'b0;
    bus.wb_cycle_i  = 1'b0;
    bus.wb_strobe_i = 1'b0;
    bus.wb_we_i     = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    check("rst_mid_ctrl0", {24'd0, ctrl_o[7:0]}, 32'h02);
    model_reset();
    wait_cycles(1);
    resetn = 1'b1;
    wait_cycles(6);
    for (int a = 0; a < 8; a++) issue(1'b0, a, 8'h00, 1'b0);
    idle();
    wait_cycles(3);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_reg_bank.md
# wb_reg_bank

Parametrised Wishbone register bank, successor to the fixed-map register file. Exposes NUM_CTRL read/write control registers, NUM_STATUS read-only status registers with input synchronisers, and NUM_EVENT sticky write-1-to-clear event registers, each paired with an interrupt mask register. It sits on the system Wishbone bus beside the existing register file and drives CPU, video and peripheral control lines from the firmware-visible map.

## Interface
- DATA_WIDTH, 8: register width in bits.
- ADDR_WIDTH, 5: register address width; the map must fit in 2**ADDR_WIDTH.
- NUM_CTRL, 4: number of R/W control registers (>=1).
- NUM_STATUS, 2: number of read-only status registers (>=0).
- NUM_EVENT, 1: number of event registers; each has a mask register (>=0).
- SYNC_STAGES, 2: synchroniser depth on status_i/event_i (0 = none, max 3).
- CTRL_RESET, '0: NUM_CTRL*DATA_WIDTH reset image; register k is bits [k*DATA_WIDTH +: DATA_WIDTH].

- wb_clock_i  in  1  system clock; all logic on its rising edge.
- wb_reset_ni  in  1  synchronous, active-low reset.
- wb_addr_i  in  ADDR_WIDTH  register address.
- wb_data_i  in  DATA_WIDTH  write data.
- wb_data_o  out  DATA_WIDTH  read data, valid while wb_ack_o is high.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_cycle_i  in  1  bus cycle active.
- wb_strobe_i  in  1  transfer request.
- wb_sel_i  in  1  write enable qualifier; writes ignored when 0.
- wb_ack_o  out  1  one-cycle transfer acknowledge.
- wb_stall_o  out  1  tied 0.
- status_i  in  NUM_STATUS*DATA_WIDTH  asynchronous status bits.
- event_i  in  NUM_EVENT*DATA_WIDTH  asynchronous event sources, rising-edge sensitive.
- ctrl_o  out  NUM_CTRL*DATA_WIDTH  control register contents.
- ctrl_wr_o  out  NUM_CTRL  one-cycle pulse when register k is written.
- irq_o  out  1  OR of all unmasked pending events, registered.

## Operation
- Address map, ascending from 0: ctrl[0..NUM_CTRL-1], status[0..NUM_STATUS-1], event[0..NUM_EVENT-1], mask[0..NUM_EVENT-1]. Other addresses read 0, ignore writes, and are still acked.
- A transfer is accepted when wb_cycle_i & wb_strobe_i. Every accepted transfer is acked. The block never stalls.
- Ctrl write: the register loads wb_data_i and ctrl_wr_o[k] pulses. Ctrl read returns the current value.
- Status read returns the synchronised status_i. Writes to status are ignored.
- Event bit j sets on a rising edge of synchronised event_i bit j. It stays set until written with 1. Writing 0 has no effect.
- If a set and a clear hit the same bit in the same cycle, the set wins.
- Mask register: R/W; bit = 1 enables that event bit onto irq_o.
- irq_o = |(event & mask) over all event registers, registered.
- Warm-up counter: after reset release, edge detection is disabled for SYNC_STAGES+1 cycles. The edge-detect history register tracks the synchronised value during warm-up, so input levels present at reset produce no events.
- Reset values:
  - ctrl_o = CTRL_RESET.
  - event, mask, ctrl_wr_o, wb_ack_o, wb_data_o, irq_o = 0.
  - Synchroniser flops = 0.
  - Warm-up counter restarts.
- Reset asserted during a transfer drops the pending ack, and the write does not occur.

## Timing
- Transfer accepted at edge N: write takes effect at edge N+1. wb_ack_o, wb_data_o and ctrl_wr_o are high for the cycle after edge N+1.
- Back-to-back transfers: strobe every cycle gives ack every cycle, in order, with no bubbles.
- Read-after-write to the same address in consecutive cycles returns the new value.
- A dropped wb_cycle_i does not cancel an already-registered ack; the master ignores it.
- Status latency: a status_i change is readable at the transfer accepted SYNC_STAGES edges later.
- Event latency: an event_i rising edge sampled at edge T sets the sticky bit at edge T+SYNC_STAGES+1. irq_o rises one edge later.
- Clearing the last unmasked pending bit drops irq_o one edge after the write takes effect.

## Test plan
- Reset with CTRL_RESET = 8'h02 in ctrl[0] -> ctrl_o[7:0] = 8'h02, irq_o = 0, wb_ack_o = 0. A read of every address returns its reset value.
- Write 8'h5A to ctrl[1], then read it back-to-back -> each ack exactly one cycle after its request, read = 8'h5A. ctrl_wr_o[1] pulses once; wb_stall_o = 0 throughout.
- Drive status_i[7:0] = 8'hA5, wait SYNC_STAGES cycles, read status[0] -> 8'hA5. Write 8'hFF to status[0] -> value unchanged.
- Hold event_i[0] high through reset -> no event after warm-up. Pulse event_i[3] -> event reads 8'h08 and irq_o stays 0. Write mask 8'h08 -> irq_o = 1. Write 8'h08 to event -> reads 8'h00 and irq_o = 0.
- Issue a W1C of bit 3 on the same cycle a new edge sets bit 3 -> bit 3 remains 1.
- Read and write an unmapped address -> acked, read returns 8'h00, no register changes. Assert reset mid-transfer -> no ack, no write.
